forward_scoreboard_id: RTL and testbench

Parametrised ID-stage forwarding and load-use hazard unit for the pipelined CPU. Holds a shadow shift register of in-flight destination tags for the DEPTH stages after ID (EX, MEM, WB, ...). For each of NUM_SRC ID source operands it selects the youngest forwardable producer, and it asserts a load-use stall when the youngest matching producer is a load whose data is not yet available. Sits beside the IF/ID register and drives the ID-stage operand muxes and the IF/ID and PC hold enables.

---
 rtl/fwd_pkg.sv | 22 ++
 rtl/fwd_src_match.sv | 47 ++++
 rtl/forward_scoreboard_id.sv | 100 ++++++++++
 tb/tb_forward_scoreboard_id.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared types and constants for the ID-stage forwarding scoreboard.
//   entry_t     : one tracked in-flight instruction (valid, regwrite, dst, is_load)
//   FWD_REGFILE : forward-select code meaning "read the register file"
//   STG_*       : stage indices after ID (1 = EX, 2 = MEM, 3 = WB)
// dst is held at MAX_AW bits so one struct serves every REG_AW up to MAX_AW;
// narrower register indices are zero-extended on entry and on compare.
package fwd_pkg;

   localparam int unsigned MAX_AW      = 8;
   localparam int unsigned FWD_REGFILE = 0;
   localparam int unsigned STG_EX      = 1;
   localparam int unsigned STG_MEM     = 2;
   localparam int unsigned STG_WB      = 3;

   typedef struct packed {
      logic              valid;
      logic              regwrite;
      logic [MAX_AW-1:0] dst;
      logic              is_load;
   } entry_t;

endpackage

// File: rtl/fwd_src_match.sv
// Per-source producer search for the ID-stage forwarding scoreboard.
//   entries  : tracked stages, entries[s-1] holds stage s (s = 1 is EX)
//   src      : register index read by this source operand
//   src_used : operand is actually read
//   id_valid : ID holds a real instruction
//   sel      : 0 = register file, s = forward from stage s (youngest match)
//   hazard   : youngest match is a load whose data is not yet forwardable
module fwd_src_match
   import fwd_pkg::*;
#(
   parameter int unsigned DEPTH            = 3,
   parameter int unsigned REG_AW           = 5,
   parameter int unsigned LOAD_READY_STAGE = 2,
   parameter int unsigned SELW             = $clog2(DEPTH + 1)
) (
   input  entry_t [DEPTH-1:0] entries,
   input  logic [REG_AW-1:0]  src,
   input  logic               src_used,
   input  logic               id_valid,
   output logic [SELW-1:0]    sel,
   output logic               hazard
);

   logic [MAX_AW-1:0] src_ext;
   int unsigned       hit_s;
   logic              hit_load;

   assign src_ext = MAX_AW'(src);

   // Scan oldest to youngest so the smallest matching stage overwrites the rest.
   always_comb begin
      hit_s    = FWD_REGFILE;
      hit_load = 1'b0;
      for (int s = DEPTH; s >= 1; s--) begin
         if (entries[s-1].valid && entries[s-1].regwrite &&
             (entries[s-1].dst != '0) && (entries[s-1].dst == src_ext) &&
             src_used && id_valid) begin
            hit_s    = s;
            hit_load = entries[s-1].is_load;
         end
      end
   end

   assign sel    = SELW'(hit_s);
   assign hazard = hit_load && (hit_s < LOAD_READY_STAGE);

endmodule

// File: rtl/forward_scoreboard_id.sv
// ID-stage forwarding and load-use hazard unit.
// Keeps a shift register of destination tags for the DEPTH stages after ID and,
// for each of NUM_SRC source operands, picks the youngest forwardable producer.
//   clk, reset_n   : clock, asynchronous active-low reset
//   pipe_advance   : pipeline moves this cycle; 0 freezes all tracked state
//   flush          : kill the instruction in ID (beats a concurrent stall)
//   id_valid       : ID holds a real instruction
//   id_src         : source k at [k*REG_AW +: REG_AW]
//   id_src_used    : source k is read
//   id_dst, id_regwrite, id_is_load : ID instruction's destination info
//   fwd_sel        : per source, 0 = register file, s = forward from stage s
//   stall_id       : hold PC and IF/ID, inject a bubble into EX
//   stall_cycles   : saturating count of stalled, advancing cycles
module forward_scoreboard_id
   import fwd_pkg::*;
#(
   parameter int unsigned NUM_SRC          = 2,
   parameter int unsigned REG_AW           = 5,
   parameter int unsigned DEPTH            = 3,
   parameter int unsigned LOAD_READY_STAGE = 2,
   parameter int unsigned SELW             = $clog2(DEPTH + 1),
   parameter int unsigned CNT_W            = 16
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      pipe_advance,
   input  logic                      flush,
   input  logic                      id_valid,
   input  logic [NUM_SRC*REG_AW-1:0] id_src,
   input  logic [NUM_SRC-1:0]        id_src_used,
   input  logic [REG_AW-1:0]         id_dst,
   input  logic                      id_regwrite,
   input  logic                      id_is_load,
   output logic [NUM_SRC*SELW-1:0]   fwd_sel,
   output logic                      stall_id,
   output logic [CNT_W-1:0]          stall_cycles
);

   entry_t [DEPTH-1:0] entries_q, entries_d;
   entry_t             new_entry;
   logic [NUM_SRC-1:0] hazard;
   logic [CNT_W-1:0]   stall_cycles_q, stall_cycles_d;

   for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
      fwd_src_match #(
         .DEPTH            (DEPTH),
         .REG_AW           (REG_AW),
         .LOAD_READY_STAGE (LOAD_READY_STAGE),
         .SELW             (SELW)
      ) u_match (
         .entries  (entries_q),
         .src      (id_src[k*REG_AW +: REG_AW]),
         .src_used (id_src_used[k]),
         .id_valid (id_valid),
         .sel      (fwd_sel[k*SELW +: SELW]),
         .hazard   (hazard[k])
      );
   end

   // Flush wins over a hazard: the killed instruction needs no operands.
   assign stall_id = (|hazard) && id_valid && !flush;

   always_comb begin
      new_entry       = '0;
      new_entry.valid = id_valid && !flush && !stall_id;
      if (new_entry.valid) begin
         new_entry.regwrite = id_regwrite;
         new_entry.dst      = MAX_AW'(id_dst);
         new_entry.is_load  = id_is_load;
      end

      entries_d = entries_q;
      if (pipe_advance) begin
         for (int s = DEPTH - 1; s >= 1; s--) begin
            entries_d[s] = entries_q[s-1];
         end
         entries_d[STG_EX-1] = new_entry;
      end
   end

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (stall_id && pipe_advance && (stall_cycles_q != '1)) begin
         stall_cycles_d = stall_cycles_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         entries_q      <= '0;
         stall_cycles_q <= '0;
      end else begin
         entries_q      <= entries_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_forward_scoreboard_id.sv
// Directed bench for forward_scoreboard_id. Stimulus pushes hand-computed
// expectations into a queue; a monitor on the falling edge pops and compares.
// A second instance with CNT_W = 4 shares the inputs to exercise saturation.
module tb_forward_scoreboard_id;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        pipe_advance;
   logic        flush;
   logic        id_valid;
   logic [9:0]  id_src;
   logic [1:0]  id_src_used;
   logic [4:0]  id_dst;
   logic        id_regwrite;
   logic        id_is_load;
   logic [3:0]  fwd_sel;
   logic        stall_id;
   logic [15:0] stall_cycles;
   logic [3:0]  sat_fwd;
   logic        sat_stall;
   logic [3:0]  sat_cycles;

   always #5 clk = ~clk;

   forward_scoreboard_id u_dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .pipe_advance (pipe_advance),
      .flush        (flush),
      .id_valid     (id_valid),
      .id_src       (id_src),
      .id_src_used  (id_src_used),
      .id_dst       (id_dst),
      .id_regwrite  (id_regwrite),
      .id_is_load   (id_is_load),
      .fwd_sel      (fwd_sel),
      .stall_id     (stall_id),
      .stall_cycles (stall_cycles)
   );

   forward_scoreboard_id #(.CNT_W(4)) u_sat (
      .clk          (clk),
      .reset_n      (reset_n),
      .pipe_advance (pipe_advance),
      .flush        (flush),
      .id_valid     (id_valid),
      .id_src       (id_src),
      .id_src_used  (id_src_used),
      .id_dst       (id_dst),
      .id_regwrite  (id_regwrite),
      .id_is_load   (id_is_load),
      .fwd_sel      (sat_fwd),
      .stall_id     (sat_stall),
      .stall_cycles (sat_cycles)
   );

   typedef struct {
      string       name;
      logic [3:0]  fwd;
      logic        stall;
      logic [15:0] cnt;
      logic [3:0]  cnt4;
   } exp_t;

   exp_t        exp_q[$];
   int          tests = 0;
   int          fails = 0;
   logic [15:0] exp_cnt;
   logic [3:0]  exp_cnt4;

   // Monitor: outputs are settled by the falling edge of each cycle.
   initial begin
      forever begin
         @(negedge clk);
         while (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            tests++;
            if (fwd_sel !== e.fwd || stall_id !== e.stall || stall_cycles !== e.cnt ||
                sat_fwd !== e.fwd || sat_stall !== e.stall || sat_cycles !== e.cnt4) begin
               fails++;
               $display("FAIL %s: got fwd=%b/%b stall=%b/%b cnt=%0d cnt4=%0d, want fwd=%b stall=%b cnt=%0d cnt4=%0d",
                        e.name, fwd_sel, sat_fwd, stall_id, sat_stall, stall_cycles, sat_cycles,
                        e.fwd, e.stall, e.cnt, e.cnt4);
            end
         end
      end
   end

   // Drive one ID cycle (just after a rising edge) and queue its expected outputs.
   // e_fwd is {sel1, sel0}.
   task automatic step(input string name, input logic adv, input logic fl, input logic vld,
                       input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used,
                       input logic [4:0] dst, input logic rw, input logic ld,
                       input logic [3:0] e_fwd, input logic e_stall);
      exp_t e;
      pipe_advance = adv;
      flush        = fl;
      id_valid     = vld;
      id_src       = {s1, s0};
      id_src_used  = used;
      id_dst       = dst;
      id_regwrite  = rw;
      id_is_load   = ld;
      e.name  = name;
      e.fwd   = e_fwd;
      e.stall = e_stall;
      e.cnt   = exp_cnt;
      e.cnt4  = exp_cnt4;
      exp_q.push_back(e);
      if (e_stall && adv) begin
         exp_cnt = exp_cnt + 16'd1;
         if (exp_cnt4 != 4'hf) exp_cnt4 = exp_cnt4 + 4'd1;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      exp_t e;
      reset_n      = 1'b0;
      pipe_advance = 1'b0;
      flush        = 1'b0;
      id_valid     = 1'b0;
      id_src       = '0;
      id_src_used  = '0;
      id_dst       = '0;
      id_regwrite  = 1'b0;
      id_is_load   = 1'b0;
      exp_cnt      = '0;
      exp_cnt4     = '0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;

      //    name               adv fl vld s0  s1  used   dst rw ld fwd      stall
      step("reset_idle",       1, 0, 1,  3,  0, 2'b01,  3, 1, 0, 4'b0000, 0);
      step("fwd_ex",           1, 0, 1,  3,  0, 2'b01,  4, 1, 0, 4'b0001, 0);
      step("fwd_mem",          1, 0, 1,  3,  3, 2'b01,  0, 0, 0, 4'b0010, 0);
      step("fwd_wb_src1",      1, 0, 1,  4,  3, 2'b11,  0, 1, 0, 4'b1110, 0);
      step("dst_zero",         1, 0, 1,  0,  4, 2'b11,  5, 1, 0, 4'b1100, 0);
      step("src_unused",       1, 0, 1,  5,  0, 2'b00,  6, 1, 0, 4'b0000, 0);
      step("r5_mem",           1, 0, 1,  5,  0, 2'b01,  5, 1, 0, 4'b0010, 0);
      step("youngest",         1, 0, 1,  5,  6, 2'b11,  0, 0, 0, 4'b1001, 0);
      step("wb_only",          1, 0, 1,  6,  0, 2'b01,  7, 1, 1, 4'b0011, 0);
      step("loaduse_stall",    1, 0, 1,  7,  0, 2'b01,  8, 1, 0, 4'b0001, 1);
      step("loaduse_resolve",  1, 0, 1,  7,  8, 2'b11,  8, 1, 0, 4'b0010, 0);
      step("after_stall",      1, 0, 1,  7,  8, 2'b11,  9, 1, 1, 4'b0111, 0);
      step("freeze_0",         0, 0, 1,  9,  0, 2'b01, 11, 1, 0, 4'b0001, 1);
      step("freeze_1",         0, 0, 1,  9,  0, 2'b01, 11, 1, 0, 4'b0001, 1);
      step("freeze_2",         0, 0, 1,  9,  0, 2'b01, 11, 1, 0, 4'b0001, 1);
      step("freeze_adv",       1, 0, 1,  9,  0, 2'b01, 11, 1, 0, 4'b0001, 1);
      step("freeze_resolve",   1, 0, 1,  9,  0, 2'b01, 11, 1, 0, 4'b0010, 0);
      step("issue_ld10",       1, 0, 1,  0,  0, 2'b00, 10, 1, 1, 4'b0000, 0);
      step("flush_hazard",     1, 1, 1, 10,  0, 2'b01, 12, 1, 0, 4'b0001, 0);
      step("flush_bubble",     1, 0, 1, 12, 10, 2'b11,  0, 0, 0, 4'b1000, 0);
      step("sat_prime",        1, 0, 1,  7,  0, 2'b01,  7, 1, 1, 4'b0000, 0);

      // Self-dependent load: stalls every other cycle, 20 stalls in total.
      for (int i = 0; i < 20; i++) begin
         step("sat_stall",     1, 0, 1,  7,  0, 2'b01,  7, 1, 1, 4'b0001, 1);
         step("sat_fwd",       1, 0, 1,  7,  0, 2'b01,  7, 1, 1, 4'b0010, 0);
      end
      step("sat_hold",         0, 0, 1,  7,  0, 2'b01,  7, 1, 1, 4'b0001, 1);

      // Asynchronous reset in the middle of a stall, away from any clock edge.
      reset_n  = 1'b0;
      exp_cnt  = '0;
      exp_cnt4 = '0;
      e.name   = "reset_mid_stall";
      e.fwd    = 4'b0000;
      e.stall  = 1'b0;
      e.cnt    = '0;
      e.cnt4   = '0;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      step("post_reset",       1, 0, 1,  7,  0, 2'b01,  7, 1, 1, 4'b0000, 0);

      @(negedge clk);
      #1;
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
